// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcodes and
// the ALU-op codes consumed by the ALU control stage.
package multicycle_control_pkg;

   typedef enum logic [3:0] {
      StFetch,
      StDecode,
      StMemAddr,
      StMemRd,
      StMemWb,
      StMemWr,
      StRExec,
      StRWb,
      StIExec,
      StIWb,
      StBranch,
      StJump
   } state_e;

   localparam logic [5:0] OpRType = 6'b000000;
   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpJ     = 6'b000010;
   localparam logic [5:0] OpAddi  = 6'b001000;
   localparam logic [5:0] OpAndi  = 6'b001100;
   localparam logic [5:0] OpOri   = 6'b001101;
   localparam logic [5:0] OpSlti  = 6'b001010;

   localparam logic [2:0] UConAdd   = 3'b000;
   localparam logic [2:0] UConSub   = 3'b001;
   localparam logic [2:0] UConFunct = 3'b010;
   localparam logic [2:0] UConAddi  = 3'b011;
   localparam logic [2:0] UConAndi  = 3'b100;
   localparam logic [2:0] UConOri   = 3'b101;
   localparam logic [2:0] UConSlti  = 3'b110;

   // ALU-op for an immediate-format instruction; unknown opcodes fall back to add.
   function automatic logic [2:0] imm_ucon(input logic [5:0] op);
      logic [2:0] u;
      u = UConAdd;
      case (op)
         OpAddi:  u = UConAddi;
         OpAndi:  u = UConAndi;
         OpOri:   u = UConOri;
         OpSlti:  u = UConSlti;
         default: u = UConAdd;
      endcase
      return u;
   endfunction

endpackage

// File: rtl/multicycle_control.sv
// Multicycle MIPS main control FSM with a retired-instruction counter.
// Control outputs decode combinationally from the state register.
module multicycle_control
   import multicycle_control_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       Opcode,
   input  logic             MemReady,
   input  logic             Zero,
   output logic             PCEn,
   output logic             IorD,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             MemtoReg,
   output logic             RegDst,
   output logic             RegWrite,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       PCSource,
   output logic [2:0]       UCon,
   output logic [CNT_W-1:0] InstrCount
);

   state_e           state_q, state_d;
   logic [5:0]       opcode_q, opcode_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             retire;

   always_comb begin
      state_d  = state_q;
      opcode_d = opcode_q;
      case (state_q)
         StFetch:   if (MemReady) state_d = StDecode;
         StDecode: begin
            opcode_d = Opcode;
            case (Opcode)
               OpLw, OpSw:                     state_d = StMemAddr;
               OpRType:                        state_d = StRExec;
               OpBeq:                          state_d = StBranch;
               OpJ:                            state_d = StJump;
               OpAddi, OpAndi, OpOri, OpSlti:  state_d = StIExec;
               default:                        state_d = StFetch;
            endcase
         end
         StMemAddr: state_d = (opcode_q == OpLw) ? StMemRd : StMemWr;
         StMemRd:   if (MemReady) state_d = StMemWb;
         StMemWr:   if (MemReady) state_d = StFetch;
         StRExec:   state_d = StRWb;
         StIExec:   state_d = StIWb;
         StMemWb, StRWb, StIWb, StBranch, StJump: state_d = StFetch;
         default:   state_d = StFetch;
      endcase
   end

   // An instruction retires on the final transition back into FETCH.
   always_comb begin
      retire = 1'b0;
      case (state_q)
         StMemWb, StRWb, StIWb, StBranch, StJump: retire = 1'b1;
         StMemWr: retire = MemReady;
         default: retire = 1'b0;
      endcase
      cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StFetch;
         opcode_q <= 6'b000000;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         opcode_q <= opcode_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      PCEn     = 1'b0;
      IorD     = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      MemtoReg = 1'b0;
      RegDst   = 1'b0;
      RegWrite = 1'b0;
      ALUSrcA  = 1'b0;
      ALUSrcB  = 2'b00;
      PCSource = 2'b00;
      UCon     = UConAdd;
      case (state_q)
         StFetch: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            IRWrite = MemReady;
            PCEn    = MemReady;
         end
         StDecode:  ALUSrcB = 2'b11;
         StMemAddr: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         StMemRd: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
         end
         StMemWr: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
         end
         StMemWb: begin
            RegWrite = 1'b1;
            MemtoReg = 1'b1;
         end
         StRExec: begin
            ALUSrcA = 1'b1;
            UCon    = UConFunct;
         end
         StRWb: begin
            RegWrite = 1'b1;
            RegDst   = 1'b1;
         end
         StIExec: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            UCon    = imm_ucon(opcode_q);
         end
         StIWb:     RegWrite = 1'b1;
         StBranch: begin
            ALUSrcA  = 1'b1;
            UCon     = UConSub;
            PCSource = 2'b01;
            PCEn     = Zero;
         end
         StJump: begin
            PCSource = 2'b10;
            PCEn     = 1'b1;
         end
         default: ;
      endcase
   end

   assign InstrCount = cnt_q;

endmodule
